bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter between the RISC-V core's display result and the four-digit seven-segment multiplexer. It takes a 16-bit binary value through a valid/ready handshake, converts it over WIDTH shift cycles, and presents registered packed BCD digits, an out-of-range flag and a completion pulse. This removes the combinational divide/modulo chain from the display path.

## Interface
- WIDTH, 16, binary input width; sets the shift-iteration count.
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1.
- clk_100mhz  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is presented for conversion.
- in_ready  output  1  converter idle and able to accept.
- in_data  input  WIDTH  unsigned binary value.
- out_valid  output  1  one-cycle pulse: bcd/overflow updated this cycle.
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- overflow  output  1  converted value > 9999, so it does not fit the 4-digit display.
- blank_mask  output  4  per-digit blank request for display digits 0..3 (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch in_data into the shift register;
  - clear the BCD scratch register;
  - load the iteration counter with WIDTH;
  - set the overflow scratch to (in_data > 9999);
  - go to SHIFT.
- SHIFT, one iteration per cycle, all in the same cycle:
  - every scratch digit >= 5 gets +3;
  - the {scratch, shift} concatenation shifts left by 1;
  - the counter decrements.
  - When the counter reaches 1 on this iteration, go to DONE.
- DONE:
  - bcd and overflow load from scratch;
  - out_valid=1 for exactly this cycle; in_ready=0;
  - next state is IDLE.
- bcd, overflow and blank_mask hold their values until the next DONE. in_valid is ignored outside IDLE; no queuing.
- Arithmetic is unsigned. The counter width is clog2(WIDTH+1). Digit correction uses 4-bit add with no carry out, because the input to +3 is at most 9.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, bcd=0, overflow=0, blank_mask=4'b1110 with the macro and 4'b0000 without it. All scratch registers and the counter are 0.
- Latency: accept edge at cycle N, out_valid high in cycle N+WIDTH+1. in_ready returns high at N+WIDTH+2.
- Throughput is one conversion per WIDTH+2 cycles (18 for the default).
- in_valid asserted continuously: a new value is accepted on every IDLE cycle.
- Reset asserted mid-conversion aborts immediately. Outputs return to reset values; no out_valid is issued for the aborted value.
- Boundaries:
  - in_data=0 gives bcd=0.
  - in_data=2^WIDTH-1 converts fully, using all DIGITS digits.

## Configuration
- Macro BCD_LEADING_BLANK_EN.
- Defined: blank_mask[i] (i=1..3) is 1 when result digit i and every display digit above it up to digit 3 are zero. blank_mask[0] is always 0, so the value 0 still shows "0". The mask is registered in DONE together with bcd. When overflow=1, blank_mask=0.
- Undefined: blank_mask is constant 4'b0000 and the logic is absent.

## Structure
- Shared package display_pkg holds:
  - BCD_DIGIT_W=4;
  - DISP_DIGITS=4;
  - DISP_MAX=9999;
  - state enum typedef {IDLE, SHIFT, DONE};
  - packed BCD digit typedef.
- Sub-module bcd_add3: combinational 4-bit cell giving d>=5 ? d+3 : d. It is instantiated DIGITS times in a generate loop.
- The FSM and datapath live in bin2bcd_seq.

## Test plan
- Reset, then idle: bcd=0, out_valid=0, in_ready=1, blank_mask=4'b1110 (macro on).
- in_data=1234 accepted at cycle N: out_valid pulses only at N+17, bcd=20'h01234, overflow=0, blank_mask=4'b0000.
- in_data=9999 gives bcd=20'h09999, overflow=0. in_data=10000 gives bcd=20'h10000, overflow=1. in_data=65535 gives bcd=20'h65535, overflow=1.
- in_data=7 gives bcd=20'h00007 and blank_mask=4'b1110 (macro on) or 4'b0000 (macro off). in_data=0 gives blank_mask=4'b1110 (macro on).
- in_valid held high with values 5, 42, 300 back-to-back: three out_valid pulses 18 cycles apart with bcd 5, 42, 300. A value changed while in_ready=0 is not converted.
- Reset pulsed 8 cycles after accepting 4321: no out_valid; bcd=0 after reset. A subsequent 4321 converts correctly.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display-path types and constants for the binary-to-BCD converter
// and the seven-segment multiplexer.
package display_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int DISP_DIGITS = 4;
  localparam int DISP_MAX    = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq.
// Carries the input valid/ready pair and the result outputs.
interface bin2bcd_seq_if
  import display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_data;
  logic                          out_valid;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          overflow;
  logic [DISP_DIGITS-1:0]        blank_mask;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, bcd, overflow, blank_mask
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, bcd, overflow, blank_mask
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
// Input never exceeds 9, so the 4-bit sum cannot carry out.
module bcd_add3
  import display_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional leading-zero blanking enabled by BCD_LEADING_BLANK_EN.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
)(
  input  logic         clk_100mhz,
  input  logic         reset,
  bin2bcd_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = BCD_DIGIT_W * DIGITS;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic             ovf_s;
  logic             last;
  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]    result;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {adj, shreg} << 1;
  assign result  = shifted[WIDTH +: BW];
  assign last    = (state == SHIFT) && (cnt == CW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_s   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg   <= bus.in_data;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            ovf_s   <= 32'(bus.in_data) > DISP_MAX;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= shifted;
          cnt              <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final shift so they are valid during DONE.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last) begin
      bcd_q <= result;
      ovf_q <= ovf_s;
    end
  end

`ifdef BCD_LEADING_BLANK_EN
  logic [DISP_DIGITS-1:0] blank_nx;
  logic [DISP_DIGITS-1:0] blank_q;
  logic                   zero_above;

  always_comb begin
    blank_nx   = '0;
    zero_above = 1'b1;
    for (int i = DISP_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above &&
        (result[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_nx[i] = zero_above;
    end
    if (ovf_s) blank_nx = '0;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset)     blank_q <= 4'b1110;
    else if (last) blank_q <= blank_nx;
  end

  assign bus.blank_mask = blank_q;
`else
  assign bus.blank_mask = '0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues expected results,
// a negedge monitor pops and compares on every out_valid.
module tb_bin2bcd_seq;
  import display_pkg::*;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
    int          acc;
  } exp_t;

  logic clk_100mhz = 1'b0;
  logic reset      = 1'b1;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_ov = -1;
  bit   b2b    = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  function automatic logic [3:0] blk(input logic [3:0] on);
`ifdef BCD_LEADING_BLANK_EN
    return on;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk_100mhz) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=%h required=none",
                 bus.bcd);
      end else begin
        mon_e = q.pop_front();
        check("bcd", 32'(bus.bcd), 32'(mon_e.bcd));
        check("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
        check("blank_mask", 32'(bus.blank_mask), 32'(mon_e.blank));
        check("latency", 32'(cyc + 1 - mon_e.acc), 32'(WIDTH + 1));
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (b2b && last_ov >= 0)
          check("spacing", 32'(cyc - last_ov), 32'(WIDTH + 2));
      end
      last_ov = cyc;
    end
  end

  task automatic send(input logic [15:0] v, input logic [19:0] eb,
                      input logic eo, input logic [3:0] ebl,
                      input bit keep);
    int n = 0;
    exp_t e;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk_100mhz);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=busy required=ready");
      bus.in_valid = 1'b0;
      return;
    end
    e.bcd   = eb;
    e.ovf   = eo;
    e.blank = blk(ebl);
    e.acc   = cyc + 1;
    q.push_back(e);
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk_100mhz);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
      q.delete();
    end
    @(negedge clk_100mhz);
  endtask

  task automatic idle_state(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, "_blank"}, 32'(bus.blank_mask), 32'(blk(4'b1110)));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk_100mhz);
    idle_state("in_reset");
    reset = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    idle_state("post_reset");

    send(16'd1234,  20'h01234, 1'b0, 4'b0000, 1'b0); drain();
    send(16'd9999,  20'h09999, 1'b0, 4'b0000, 1'b0); drain();
    send(16'd10000, 20'h10000, 1'b1, 4'b0000, 1'b0); drain();
    send(16'd65535, 20'h65535, 1'b1, 4'b0000, 1'b0); drain();
    send(16'd7,     20'h00007, 1'b0, 4'b1110, 1'b0); drain();
    send(16'd0,     20'h00000, 1'b0, 4'b1110, 1'b0); drain();

    b2b     = 1'b1;
    last_ov = -1;
    send(16'd5, 20'h00005, 1'b0, 4'b1110, 1'b1);
    bus.in_data = 16'd999;
    repeat (5) @(negedge clk_100mhz);
    send(16'd42,  20'h00042, 1'b0, 4'b1100, 1'b1);
    send(16'd300, 20'h00300, 1'b0, 4'b1000, 1'b0);
    drain();
    b2b = 1'b0;

    send(16'd4321, 20'h04321, 1'b0, 4'b0000, 1'b0);
    repeat (8) @(negedge clk_100mhz);
    reset = 1'b1;
    q.delete();
    repeat (2) @(negedge clk_100mhz);
    idle_state("abort_reset");
    reset = 1'b0;
    @(negedge clk_100mhz);
    idle_state("abort_post");
    repeat (20) @(negedge clk_100mhz);
    send(16'd4321, 20'h04321, 1'b0, 4'b0000, 1'b0); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
